// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier with flush-to-zero inputs, rounding and exception flags.
// Define FP_MUL_RMODE_EN to add the rmode port (00 RNE, 01 RTZ, 10 RUP, 11 RDN); otherwise rounding is RNE only.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef FP_MUL_RMODE_EN
  input  logic [1:0]   rmode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int EW = EXP_W + 3;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS_S   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  logic [1:0] in_rm;

  logic                 s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
  logic signed [EW-1:0] s1_exp_q, s1_exp_d;
  logic [MAN_W:0]       s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
  logic                 s1_special_q, s1_special_d, s1_spec_inv_q, s1_spec_inv_d;
  logic [W-1:0]         s1_spec_res_q, s1_spec_res_d;
  logic [1:0]           s1_rm_q, s1_rm_d;

  logic                 s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
  logic signed [EW-1:0] s2_exp_q, s2_exp_d;
  logic [PW-1:0]        s2_prod_q, s2_prod_d;
  logic                 s2_special_q, s2_special_d, s2_spec_inv_q, s2_spec_inv_d;
  logic [W-1:0]         s2_spec_res_q, s2_spec_res_d;
  logic [1:0]           s2_rm_q, s2_rm_d;

  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         result_q, result_d;
  logic [3:0]           flags_q, flags_d;

`ifdef FP_MUL_RMODE_EN
  assign in_rm = rmode;
`else
  assign in_rm = 2'b00;
`endif

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // Stage 1: unpack, classify, sign and biased exponent sum
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan, prod_sign;

  assign a_exp     = a[W-2:MAN_W];
  assign b_exp     = b[W-2:MAN_W];
  assign a_frac    = a[MAN_W-1:0];
  assign b_frac    = b[MAN_W-1:0];
  assign a_nan     = (a_exp == '1) && (a_frac != '0);
  assign b_nan     = (b_exp == '1) && (b_frac != '0);
  assign a_inf     = (a_exp == '1) && (a_frac == '0);
  assign b_inf     = (b_exp == '1) && (b_frac == '0);
  assign a_zero    = (a_exp == '0);
  assign b_zero    = (b_exp == '0);
  assign a_snan    = a_nan && !a_frac[MAN_W-1];
  assign b_snan    = b_nan && !b_frac[MAN_W-1];
  assign prod_sign = a[W-1] ^ b[W-1];

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_sign_d     = s1_sign_q;
    s1_exp_d      = s1_exp_q;
    s1_ma_d       = s1_ma_q;
    s1_mb_d       = s1_mb_q;
    s1_special_d  = s1_special_q;
    s1_spec_inv_d = s1_spec_inv_q;
    s1_spec_res_d = s1_spec_res_q;
    s1_rm_d       = s1_rm_q;
    if (advance) begin
      s1_valid_d    = in_valid;
      s1_sign_d     = prod_sign;
      s1_exp_d      = $signed({3'b000, a_exp}) + $signed({3'b000, b_exp}) - BIAS_S;
      s1_ma_d       = {1'b1, a_frac};
      s1_mb_d       = {1'b1, b_frac};
      s1_rm_d       = in_rm;
      s1_special_d  = 1'b1;
      s1_spec_inv_d = 1'b0;
      s1_spec_res_d = '0;
      // Priority: NaN, inf*0, inf, zero (subnormals count as zero)
      if (a_nan || b_nan) begin
        s1_spec_res_d = QNAN;
        s1_spec_inv_d = a_snan || b_snan;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
        s1_spec_res_d = QNAN;
        s1_spec_inv_d = 1'b1;
      end else if (a_inf || b_inf) begin
        s1_spec_res_d = {prod_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
        s1_spec_res_d = {prod_sign, {(W-1){1'b0}}};
      end else begin
        s1_special_d  = 1'b0;
      end
    end
  end

  // Stage 2: significand multiply
  always_comb begin
    s2_valid_d    = s2_valid_q;
    s2_sign_d     = s2_sign_q;
    s2_exp_d      = s2_exp_q;
    s2_prod_d     = s2_prod_q;
    s2_special_d  = s2_special_q;
    s2_spec_inv_d = s2_spec_inv_q;
    s2_spec_res_d = s2_spec_res_q;
    s2_rm_d       = s2_rm_q;
    if (advance) begin
      s2_valid_d    = s1_valid_q;
      s2_sign_d     = s1_sign_q;
      s2_exp_d      = s1_exp_q;
      s2_prod_d     = PW'(s1_ma_q) * PW'(s1_mb_q);
      s2_special_d  = s1_special_q;
      s2_spec_inv_d = s1_spec_inv_q;
      s2_spec_res_d = s1_spec_res_q;
      s2_rm_d       = s1_rm_q;
    end
  end

  // Stage 3: normalise, round, detect range exceptions, pack
  logic                 top, guard, sticky, inc, carry, sat_max;
  logic [MAN_W-1:0]     frac_t;
  logic [MAN_W:0]       rnd;
  logic signed [EW-1:0] exp_n, exp_r;

  always_comb begin
    top     = s2_prod_q[PW-1];
    frac_t  = top ? s2_prod_q[PW-2:MAN_W+1] : s2_prod_q[PW-3:MAN_W];
    guard   = top ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
    sticky  = top ? |s2_prod_q[MAN_W-1:0] : |s2_prod_q[MAN_W-2:0];
    exp_n   = s2_exp_q + $signed({{(EW-1){1'b0}}, top});
    case (s2_rm_q)
      2'b01:   inc = 1'b0;
      2'b10:   inc = !s2_sign_q && (guard || sticky);
      2'b11:   inc = s2_sign_q && (guard || sticky);
      default: inc = guard && (sticky || frac_t[0]);
    endcase
    rnd     = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
    carry   = rnd[MAN_W];
    exp_r   = exp_n + $signed({{(EW-1){1'b0}}, carry});
    // Directed modes rounding away from the overflow sign saturate to max finite
    sat_max = (s2_rm_q == 2'b01) || (s2_rm_q == 2'b10 && s2_sign_q) ||
              (s2_rm_q == 2'b11 && !s2_sign_q);

    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (advance) begin
      out_valid_d = s2_valid_q;
      if (s2_special_q) begin
        result_d = s2_spec_res_q;
        flags_d  = {s2_spec_inv_q, 3'b000};
      end else if (exp_r >= EXP_MAX) begin
        result_d = sat_max ? {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                           : {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d  = 4'b0101;
      end else if (exp_r <= EXP_ZERO) begin
        result_d = {s2_sign_q, {(W-1){1'b0}}};
        flags_d  = 4'b0011;
      end else begin
        result_d = {s2_sign_q, exp_r[EXP_W-1:0], rnd[MAN_W-1:0]};
        flags_d  = {3'b000, guard || sticky};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_ma_q       <= '0;
      s1_mb_q       <= '0;
      s1_special_q  <= 1'b0;
      s1_spec_inv_q <= 1'b0;
      s1_spec_res_q <= '0;
      s1_rm_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_prod_q     <= '0;
      s2_special_q  <= 1'b0;
      s2_spec_inv_q <= 1'b0;
      s2_spec_res_q <= '0;
      s2_rm_q       <= '0;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      flags_q       <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_exp_q      <= s1_exp_d;
      s1_ma_q       <= s1_ma_d;
      s1_mb_q       <= s1_mb_d;
      s1_special_q  <= s1_special_d;
      s1_spec_inv_q <= s1_spec_inv_d;
      s1_spec_res_q <= s1_spec_res_d;
      s1_rm_q       <= s1_rm_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_exp_q      <= s2_exp_d;
      s2_prod_q     <= s2_prod_d;
      s2_special_q  <= s2_special_d;
      s2_spec_inv_q <= s2_spec_inv_d;
      s2_spec_res_q <= s2_spec_res_d;
      s2_rm_q       <= s2_rm_d;
      out_valid_q   <= out_valid_d;
      result_q      <= result_d;
      flags_q       <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe at single-precision widths: directed vectors, stall/backpressure,
// mid-flight reset and randomized operands scored against an integer-arithmetic reference model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [35:0] exp_q[$];
  int          acc_q[$];
  logic [35:0] cur_exp, held;
  bit lat_check = 0, rand_ready = 0, saw_not_ready = 0, held_v = 0, accepted = 0;
  int stall_from = -1, stall_to = -1, n_out = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product, RNE at normal precision, then range checks.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    logic [22:0] fx, fy;
    logic s, xn, yn, xi, yi, xz, yz, inx;
    longint p, q, rem, half;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = x[22:0]; fy = y[22:0];
    s  = x[31] ^ y[31];
    xn = (ex == 255) && (fx != 0); yn = (ey == 255) && (fy != 0);
    xi = (ex == 255) && (fx == 0); yi = (ey == 255) && (fy == 0);
    xz = (ex == 0);                yz = (ey == 0);
    if (xn || yn) return {((xn && !fx[22]) || (yn && !fy[22])), 3'b000, 32'hFFC00000};
    if ((xi && yz) || (yi && xz)) return {4'b1000, 32'hFFC00000};
    if (xi || yi) return {4'b0000, s, 8'hFF, 23'd0};
    if (xz || yz) return {4'b0000, s, 31'd0};
    p    = longint'({1'b1, fx}) * longint'({1'b1, fy});
    sh   = (p >= (longint'(1) << 47)) ? 24 : 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    e    = ex + ey - 127 + (sh - 23);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (longint'(1) << 24)) begin q = q >> 1; e = e + 1; end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b0011, s, 31'd0};
    return {3'b000, inx, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       r[30:23] = 8'd0;
      1:       r[30:23] = 8'hFF;
      2:       begin r[30:23] = 8'hFF; r[22:0] = '0; end
      3:       r[30:0] = '0;
      4:       r[30:23] = 8'($urandom_range(1, 12));
      5:       r[30:23] = 8'($urandom_range(240, 254));
      default: r[30:23] = 8'($urandom_range(90, 165));
    endcase
    return r;
  endfunction

  // One clock cycle: set out_ready, sample at negedge, score, then step past the posedge.
  task automatic tick();
    logic [35:0] e;
    int ac;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else            out_ready = !(cyc >= stall_from && cyc < stall_to);
    @(negedge clk);
    accepted = 0;
    if (!in_ready) saw_not_ready = 1;
    if (out_valid && !out_ready) begin
      if (held_v) check("stall_hold", {flags, result}, held);
      held_v = 1;
      held   = {flags, result};
    end else begin
      held_v = 0;
    end
    if (out_valid && out_ready) begin
      n_out++;
      check("queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ac = acc_q.pop_front();
        check("result", result, e[31:0]);
        check("flags", flags, e[35:32]);
        if (lat_check) check("latency", 64'(cyc - ac), 64'd3);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      acc_q.push_back(cyc);
      accepted = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [35:0] expv);
    a = x; b = y; cur_exp = expv; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) check("accept_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic send_model(input logic [31:0] x, input logic [31:0] y);
    send(x, y, ref_mul(x, y));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Directed vectors, no stalls, latency checked
    lat_check = 1;
    send(32'h40400000, 32'h40000000, {4'b0000, 32'h40C00000});
    drain();
    send(32'h42C80000, 32'h3EAAAAAB, {4'b0001, 32'h42055556});
    send(32'hC2480000, 32'hC1C00000, {4'b0000, 32'h44960000});
    send(32'h7F800000, 32'h00000000, {4'b1000, 32'hFFC00000});
    send(32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000});
    send(32'h7F7FFFFF, 32'h40000000, {4'b0101, 32'h7F800000});
    send(32'h00800000, 32'h3F000000, {4'b0011, 32'h00000000});
    send(32'h7F800001, 32'h3F800000, {4'b1000, 32'hFFC00000});
    send(32'h7FC00000, 32'h00000000, {4'b0000, 32'hFFC00000});
    send(32'h00000000, 32'hC0A00000, {4'b0000, 32'h80000000});
    send(32'h00000001, 32'h3F800000, {4'b0000, 32'h00000000});
    send(32'hFF800000, 32'hFF800000, {4'b0000, 32'h7F800000});
    drain();

    // Six back-to-back ops with out_ready low on stream cycles 4-7
    lat_check = 0; saw_not_ready = 0; n_out = 0;
    stall_from = cyc + 4; stall_to = cyc + 8;
    for (int i = 0; i < 6; i++) send_model(rand_op(), rand_op());
    drain();
    check("stall_in_ready_drop", 64'(saw_not_ready), 64'd1);
    check("stall_count", 64'(n_out), 64'd6);
    stall_from = -1; stall_to = -1;

    // Randomized traffic with random gaps and random backpressure
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      send_model(rand_op(), rand_op());
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    drain();
    rand_ready = 0;

    // Reset with two ops in flight
    stall_from = cyc; stall_to = cyc + 1000;
    send_model(32'h40400000, 32'h40400000);
    send_model(32'h3F800000, 32'h40A00000);
    in_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", flags, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    acc_q.delete();
    held_v = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall_from = -1; stall_to = -1;
    lat_check = 1; n_out = 0;
    send_model(32'hC0000000, 32'h40400000);
    in_valid = 1'b0;
    repeat (8) tick();
    check("post_rst_single_count", 64'(n_out), 64'd1);
    check("post_rst_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
